mem_stage_ctrl: RTL and testbench

//  MEM-stage data-memory access controller. Sits between EX/MEM and MEM/WB: takes the
//  EX/MEM address, store data and control, and runs one req/ack bus transaction per access.

---
 rtl/mem_stage_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// MEM-stage data-memory access controller. Takes the EX/MEM address, store
// data and control, runs one req/ack bus transaction per access, and holds
// the pipeline via Stall until the transaction completes. Load data is
// aligned and extended, then presented as ReadDataFromMem_MEM for MEM/WB.
// Word, half and byte accesses are little-endian; misaligned accesses raise
// AddrErr without a bus cycle, and unacknowledged accesses raise Timeout.
//
// Ports
//   Clk, Reset           clock, synchronous active-high reset
//   MemRead_MEM          load request
//   MemWrite_MEM         store request (wins over a simultaneous load)
//   MemSize_MEM          00 word, 01 half, 10 byte, 11 word
//   MemSigned_MEM        1 = sign-extend sub-word loads
//   ALUResult_MEM        effective byte address
//   WriteData_MEM        store data, value in low bits
//   BusReq/BusWe/BusAddr/BusByteEn/BusWData   registered bus request
//   BusAck, BusRData     completion strobe and read data from memory
//   ReadDataFromMem_MEM  formatted load result, held until the next read
//   Stall                combinational pipeline freeze
//   AddrErr, Timeout     one-cycle error pulses
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 9
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MemRead_MEM,
   input  logic        MemWrite_MEM,
   input  logic [1:0]  MemSize_MEM,
   input  logic        MemSigned_MEM,
   input  logic [31:0] ALUResult_MEM,
   input  logic [31:0] WriteData_MEM,
   output logic        BusReq,
   output logic        BusWe,
   output logic [31:0] BusAddr,
   output logic [3:0]  BusByteEn,
   output logic [31:0] BusWData,
   input  logic        BusAck,
   input  logic [31:0] BusRData,
   output logic [31:0] ReadDataFromMem_MEM,
   output logic        Stall,
   output logic        AddrErr,
   output logic        Timeout
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_e;

   // Last counter value of an access; unused when the timeout is disabled.
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [31:0]       bus_addr_q, bus_addr_d;
   logic [3:0]        bus_be_q, bus_be_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              addr_err_q, addr_err_d;
   logic              timeout_q, timeout_d;
   // Access attributes kept for formatting the read data when the ack arrives.
   logic              is_read_q, is_read_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [1:0]        lane_q, lane_d;

   // Request decode from the EX/MEM inputs.
   logic        req;
   logic        is_half, is_byte;
   logic [1:0]  lane;
   logic        misaligned;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic [31:0] load_data;
   logic [7:0]  load_byte;
   logic [15:0] load_half;

   assign req     = MemRead_MEM | MemWrite_MEM;
   assign is_half = (MemSize_MEM == 2'b01);
   assign is_byte = (MemSize_MEM == 2'b10);
   assign lane    = ALUResult_MEM[1:0];

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the case/if tree can leave it unassigned and infer a latch.
   always_comb begin
      misaligned = 1'b0;
      req_be     = 4'b1111;
      req_wdata  = WriteData_MEM;
      if (is_byte) begin
         req_be    = 4'b0001 << lane;
         req_wdata = {4{WriteData_MEM[7:0]}};
      end else if (is_half) begin
         misaligned = lane[0];
         req_be     = lane[1] ? 4'b1100 : 4'b0011;
         req_wdata  = {2{WriteData_MEM[15:0]}};
      end else begin
         misaligned = (lane != 2'b00);
      end
   end

   // Lane-select and extend the bus read data using the captured attributes.
   always_comb begin
      load_byte = BusRData[{lane_q, 3'b000} +: 8];
      load_half = BusRData[{lane_q[1], 4'b0000} +: 16];
      load_data = BusRData;
      if (size_q == 2'b10) begin
         load_data = signed_q ? {{24{load_byte[7]}}, load_byte} : {24'h0, load_byte};
      end else if (size_q == 2'b01) begin
         load_data = signed_q ? {{16{load_half[15]}}, load_half} : {16'h0, load_half};
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      rdata_d     = rdata_q;
      addr_err_d  = 1'b0;
      timeout_d   = 1'b0;
      is_read_d   = is_read_q;
      size_d      = size_q;
      signed_d    = signed_q;
      lane_d      = lane_q;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (misaligned) begin
                  addr_err_d = 1'b1;
               end else begin
                  bus_req_d   = 1'b1;
                  bus_we_d    = MemWrite_MEM;
                  bus_addr_d  = {ALUResult_MEM[31:2], 2'b00};
                  bus_be_d    = req_be;
                  bus_wdata_d = req_wdata;
                  is_read_d   = ~MemWrite_MEM;
                  size_d      = MemSize_MEM;
                  signed_d    = MemSigned_MEM;
                  lane_d      = lane;
                  cnt_d       = '0;
                  state_d     = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            // An ack in the final counted cycle still completes normally.
            if (BusAck) begin
               bus_req_d = 1'b0;
               if (is_read_q) rdata_d = load_data;
               cnt_d     = '0;
               state_d   = S_DONE;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
               bus_req_d = 1'b0;
               timeout_d = 1'b1;
               if (is_read_q) rdata_d = 32'h0;
               cnt_d     = '0;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            // The pipeline advances past this instruction at this edge, so
            // its still-present request must not start a second access.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values and simulation matches the synthesized netlist.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'h0;
         bus_be_q    <= 4'h0;
         bus_wdata_q <= 32'h0;
         rdata_q     <= 32'h0;
         addr_err_q  <= 1'b0;
         timeout_q   <= 1'b0;
         is_read_q   <= 1'b0;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         lane_q      <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         rdata_q     <= rdata_d;
         addr_err_q  <= addr_err_d;
         timeout_q   <= timeout_d;
         is_read_q   <= is_read_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         lane_q      <= lane_d;
      end
   end

   // Stall covers the request cycle and every ACCESS cycle; DONE releases it.
   assign Stall = ~Reset &
                  ((state_q == S_ACCESS) | ((state_q == S_IDLE) & req & ~misaligned));

   assign BusReq              = bus_req_q;
   assign BusWe               = bus_we_q;
   assign BusAddr             = bus_addr_q;
   assign BusByteEn           = bus_be_q;
   assign BusWData            = bus_wdata_q;
   assign ReadDataFromMem_MEM = rdata_q;
   assign AddrErr             = addr_err_q;
   assign Timeout             = timeout_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

   localparam int TO = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        MemRead_MEM, MemWrite_MEM, MemSigned_MEM;
   logic [1:0]  MemSize_MEM;
   logic [31:0] ALUResult_MEM, WriteData_MEM;
   logic        BusReq, BusWe, BusAck;
   logic [31:0] BusAddr, BusWData, BusRData, ReadDataFromMem_MEM;
   logic [3:0]  BusByteEn;
   logic        Stall, AddrErr, Timeout;

   int total = 0;
   int bad   = 0;

   mem_stage_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
      .Clk(Clk), .Reset(Reset),
      .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
      .MemSize_MEM(MemSize_MEM), .MemSigned_MEM(MemSigned_MEM),
      .ALUResult_MEM(ALUResult_MEM), .WriteData_MEM(WriteData_MEM),
      .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr),
      .BusByteEn(BusByteEn), .BusWData(BusWData),
      .BusAck(BusAck), .BusRData(BusRData),
      .ReadDataFromMem_MEM(ReadDataFromMem_MEM),
      .Stall(Stall), .AddrErr(AddrErr), .Timeout(Timeout)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdat;
      int          dly;     // ACCESS cycle carrying the ack; 0 = never
      logic        ewe;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      logic [31:0] eout;
      logic        eerr;
      logic        eto;
      int          estall;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge Clk);
      #1;
   endtask

   task automatic clear_inputs();
      MemRead_MEM   = 1'b0;
      MemWrite_MEM  = 1'b0;
      MemSize_MEM   = 2'b00;
      MemSigned_MEM = 1'b0;
      ALUResult_MEM = 32'h0;
      WriteData_MEM = 32'h0;
   endtask

   // Drives one access and answers it with an ack in ACCESS cycle 'dly'.
   task automatic run_txn(input string nm, input vec_t v);
      int   stall_cyc = 0;
      int   acc = 0;
      int   guard = 0;
      logic [31:0] g_addr = 32'h0, g_wd = 32'h0;
      logic        g_we = 1'b0;
      logic [3:0]  g_be = 4'h0;
      MemRead_MEM   = v.rd;
      MemWrite_MEM  = v.wr;
      MemSize_MEM   = v.sz;
      MemSigned_MEM = v.sg;
      ALUResult_MEM = v.addr;
      WriteData_MEM = v.wd;
      #1;
      while (Stall && guard < 20) begin
         guard++;
         stall_cyc++;
         if (BusReq) begin
            acc++;
            if (acc == 1) begin
               g_addr = BusAddr; g_we = BusWe; g_be = BusByteEn; g_wd = BusWData;
            end
            BusAck   = (v.dly != 0) && (acc == v.dly);
            BusRData = BusAck ? v.rdat : 32'h0BAD_0BAD;
         end
         step();
         BusAck = 1'b0;
      end
      check({nm, "_bounded"}, 32'(guard < 20), 32'd1);
      check({nm, "_stall"}, stall_cyc, v.estall);
      if (v.estall > 0) begin
         check({nm, "_reqcyc"}, acc, v.estall - 1);
         check({nm, "_addr"}, g_addr, {v.addr[31:2], 2'b00});
         check({nm, "_we"}, 32'(g_we), 32'(v.ewe));
         check({nm, "_be"}, 32'(g_be), 32'(v.ebe));
         if (v.ewe) check({nm, "_wdata"}, g_wd, v.ewd);
         check({nm, "_req_off"}, 32'(BusReq), 32'd0);
         check({nm, "_timeout"}, 32'(Timeout), 32'(v.eto));
         check({nm, "_adderr"}, 32'(AddrErr), 32'd0);
         check({nm, "_out"}, ReadDataFromMem_MEM, v.eout);
         clear_inputs();
         step();
         check({nm, "_to_pulse"}, 32'(Timeout), 32'd0);
         check({nm, "_stall_idle"}, 32'(Stall), 32'd0);
      end else begin
         step();
         check({nm, "_adderr"}, 32'(AddrErr), 32'(v.eerr));
         check({nm, "_no_req"}, 32'(BusReq), 32'd0);
         clear_inputs();
         step();
         check({nm, "_err_pulse"}, 32'(AddrErr), 32'd0);
         check({nm, "_out"}, ReadDataFromMem_MEM, v.eout);
      end
   endtask

   // Reference model: access width in bytes drives all lane arithmetic.
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
   endfunction

   function automatic vec_t model(input vec_t v, input logic [31:0] last_out);
      vec_t r = v;
      int   n = nbytes(v.sz);
      int   lane = int'(v.addr[1:0]);
      logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
      logic [31:0] val;
      logic [31:0] rep = (n == 4) ? 32'h1 : (n == 2) ? 32'h0001_0001 : 32'h0101_0101;
      bit timed_out = (v.dly == 0) || (v.dly > TO);
      r.eerr   = (lane % n) != 0;
      r.ewe    = v.wr;
      r.ebe    = 4'(((1 << n) - 1) << lane);
      r.ewd    = (v.wd & mask) * rep;
      val      = (v.rdat >> (8 * lane)) & mask;
      if (v.sg && n < 4 && val[8*n-1]) val = val | ~mask;
      r.eto    = !r.eerr && timed_out;
      r.estall = r.eerr ? 0 : 1 + (timed_out ? TO : v.dly);
      if (r.eerr || v.wr) r.eout = last_out;
      else if (timed_out) r.eout = 32'h0;
      else r.eout = val;
      return r;
   endfunction

   initial begin
      logic [31:0] last;
      vec_t        rv;
      //          rd   wr   sz     sg   addr          wd            rdat          dly we   be       wdata         out           err  to  stall
      vecs[0]  = '{1'b1,1'b0,2'b00,1'b0,32'h0000_0100,32'h0,        32'hDEAD_BEEF,3, 1'b0,4'b1111,32'h0,        32'hDEAD_BEEF,1'b0,1'b0,4};
      vecs[1]  = '{1'b1,1'b0,2'b10,1'b1,32'h0000_0103,32'h0,        32'h80FF_1234,1, 1'b0,4'b1000,32'h0,        32'hFFFF_FF80,1'b0,1'b0,2};
      vecs[2]  = '{1'b1,1'b0,2'b10,1'b0,32'h0000_0103,32'h0,        32'h80FF_1234,1, 1'b0,4'b1000,32'h0,        32'h0000_0080,1'b0,1'b0,2};
      vecs[3]  = '{1'b0,1'b1,2'b01,1'b0,32'h0000_0102,32'h0000_ABCD,32'h0,        2, 1'b1,4'b1100,32'hABCD_ABCD,32'h0000_0080,1'b0,1'b0,3};
      vecs[4]  = '{1'b1,1'b0,2'b00,1'b0,32'h0000_0101,32'h0,        32'h0,        1, 1'b0,4'b0000,32'h0,        32'h0000_0080,1'b1,1'b0,0};
      vecs[5]  = '{1'b1,1'b0,2'b01,1'b1,32'h0000_0102,32'h0,        32'h8001_7FFF,1, 1'b0,4'b1100,32'h0,        32'hFFFF_8001,1'b0,1'b0,2};
      vecs[6]  = '{1'b1,1'b0,2'b01,1'b0,32'h0000_0100,32'h0,        32'h8001_F00F,1, 1'b0,4'b0011,32'h0,        32'h0000_F00F,1'b0,1'b0,2};
      vecs[7]  = '{1'b1,1'b0,2'b00,1'b0,32'h0000_0200,32'h0,        32'h0,        0, 1'b0,4'b1111,32'h0,        32'h0000_0000,1'b0,1'b1,5};
      vecs[8]  = '{1'b0,1'b1,2'b10,1'b0,32'h0000_0201,32'h1234_56A5,32'h0,        1, 1'b1,4'b0010,32'hA5A5_A5A5,32'h0000_0000,1'b0,1'b0,2};
      vecs[9]  = '{1'b0,1'b1,2'b01,1'b0,32'h0000_0103,32'h0000_1111,32'h0,        1, 1'b1,4'b0000,32'h0,        32'h0000_0000,1'b1,1'b0,0};
      vecs[10] = '{1'b1,1'b0,2'b11,1'b0,32'h0000_0204,32'h0,        32'h0123_4567,4, 1'b0,4'b1111,32'h0,        32'h0123_4567,1'b0,1'b0,5};
      vecs[11] = '{1'b1,1'b0,2'b10,1'b1,32'h0000_0201,32'h0,        32'h0000_7F00,1, 1'b0,4'b0010,32'h0,        32'h0000_007F,1'b0,1'b0,2};
      vecs[12] = '{1'b0,1'b1,2'b00,1'b0,32'h0000_0300,32'h0000_0055,32'h0,        0, 1'b1,4'b1111,32'h0000_0055,32'h0000_007F,1'b0,1'b1,5};
      vecs[13] = '{1'b1,1'b1,2'b00,1'b0,32'h0000_0304,32'hCAFE_F00D,32'h1111_2222,1, 1'b1,4'b1111,32'hCAFE_F00D,32'h0000_007F,1'b0,1'b0,2};

      Reset = 1'b1;
      BusAck = 1'b0;
      BusRData = 32'h0;
      clear_inputs();
      repeat (2) step();
      check("rst_req", 32'(BusReq), 32'd0);
      check("rst_be", 32'(BusByteEn), 32'd0);
      check("rst_out", ReadDataFromMem_MEM, 32'h0);
      check("rst_stall", 32'(Stall), 32'd0);
      Reset = 1'b0;
      step();

      // Table-driven directed vectors.
      for (int i = 0; i < 14; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

      // Ack outside ACCESS is ignored.
      BusAck = 1'b1;
      BusRData = 32'hFFFF_FFFF;
      step();
      BusAck = 1'b0;
      check("stray_ack_req", 32'(BusReq), 32'd0);
      check("stray_ack_out", ReadDataFromMem_MEM, 32'h0000_007F);

      // Randomized accesses against the reference model.
      last = ReadDataFromMem_MEM === 32'h0000_007F ? 32'h0000_007F : 32'h0000_007F;
      for (int i = 0; i < 60; i++) begin
         int kind = $urandom_range(0, 2);
         rv.rd   = (kind != 1);
         rv.wr   = (kind != 0);
         rv.sz   = 2'($urandom_range(0, 3));
         rv.sg   = 1'($urandom_range(0, 1));
         rv.addr = 32'h0000_1000 + 32'($urandom_range(0, 255));
         rv.wd   = $urandom;
         rv.rdat = $urandom;
         rv.dly  = $urandom_range(0, 6);
         rv      = model(rv, last);
         last    = rv.eout;
         run_txn($sformatf("rnd%0d", i), rv);
      end

      // Reset in the second ACCESS cycle aborts the transfer silently.
      MemRead_MEM   = 1'b1;
      ALUResult_MEM = 32'h0000_0400;
      #1;
      check("abort_stall_req", 32'(Stall), 32'd1);
      step();
      check("abort_acc1", 32'(BusReq), 32'd1);
      step();
      check("abort_acc2", 32'(BusReq), 32'd1);
      Reset = 1'b1;
      #1;
      check("abort_stall_forced", 32'(Stall), 32'd0);
      step();
      check("abort_req", 32'(BusReq), 32'd0);
      check("abort_addr", BusAddr, 32'h0);
      check("abort_be", 32'(BusByteEn), 32'd0);
      check("abort_out", ReadDataFromMem_MEM, 32'h0);
      check("abort_to", 32'(Timeout), 32'd0);
      Reset = 1'b0;
      clear_inputs();
      BusAck = 1'b1;
      BusRData = 32'h1234_5678;
      step();
      BusAck = 1'b0;
      check("late_ack_req", 32'(BusReq), 32'd0);
      check("late_ack_out", ReadDataFromMem_MEM, 32'h0);
      check("late_ack_to", 32'(Timeout), 32'd0);
      check("late_ack_err", 32'(AddrErr), 32'd0);
      check("late_ack_stall", 32'(Stall), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
